// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: handshake-driven multicycle control FSM with folded PC-select, retire counter and memory timeout
module multicycle_ctrl_fsm #(
   parameter int EX_CYCLES   = 1,
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       opcode,
   input  logic [5:0]       func_code,
   input  logic             bcond,
   input  logic             mem_ack,
   output logic [2:0]       state,
   output logic             mem_read,
   output logic             mem_write,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             ab_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             pc_write,
   output logic [1:0]       pc_source,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             wwd,
   output logic             halt,
   output logic             mem_err,
   output logic [CNT_W-1:0] inst_count
);
   localparam int WW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
   typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5} st_t;
   st_t st, nxt;
   logic [3:0] ex_cnt, op_q, op;
   logic [5:0] fn_q, fn;
   logic [WW-1:0] wait_cnt;
   logic is_r, is_br, is_imm, is_lwd, is_swd, is_jmp, is_jal;
   logic is_hlt, is_wwd, is_jpr, is_jrl, r_ok, illegal, ex_last, to, ack, mem_st;
   assign op      = st == S_ID ? opcode : op_q;
   assign fn      = st == S_ID ? func_code : fn_q;
   assign is_r    = op == 4'd15;
   assign is_br   = op <= 4'd3;
   assign is_imm  = op >= 4'd4 && op <= 4'd8;
   assign is_lwd  = op == 4'd7;
   assign is_swd  = op == 4'd8;
   assign is_jmp  = op == 4'd9;
   assign is_jal  = op == 4'd10;
   assign is_jpr  = is_r && fn == 6'd25;
   assign is_jrl  = is_r && fn == 6'd26;
   assign is_wwd  = is_r && fn == 6'd28;
   assign is_hlt  = is_r && fn == 6'd29;
   assign r_ok    = fn <= 6'd7 || fn == 6'd25 || fn == 6'd26 || fn == 6'd28 || fn == 6'd29;
   assign illegal = (op >= 4'd11 && op <= 4'd14) || (is_r && !r_ok);
   assign ex_last = ex_cnt == 4'(EX_CYCLES - 1);
   assign mem_st  = st == S_IF || st == S_MEM;
   // An expired wait wins over an ack arriving in the same cycle.
   assign to      = MEM_TIMEOUT > 0 && mem_st && wait_cnt == WW'(MEM_TIMEOUT);
   assign ack     = mem_ack && !to;
   assign state   = st;
   always_comb begin
      nxt        = st;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      ab_write   = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      pc_write   = 1'b0;
      pc_source  = 2'd0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      wwd        = 1'b0;
      halt       = 1'b0;
      case (st)
         S_IF: begin
            mem_read = 1'b1;
            ir_write = ack;
            nxt      = to ? S_HALT : ack ? S_ID : S_IF;
         end
         S_ID: begin
            ab_write  = 1'b1;
            pc_write  = is_jmp || illegal;
            pc_source = is_jmp ? 2'd2 : 2'd0;
            nxt       = is_hlt ? S_HALT : (is_jmp || illegal) ? S_IF : S_EX;
         end
         S_EX: begin
            alu_src_a = !is_jal;
            alu_src_b = is_imm ? 2'd2 : is_jal ? 2'd1 : 2'd0;
            if (ex_last) begin
               pc_write  = is_br || is_wwd || is_jpr;
               wwd       = is_wwd;
               pc_source = is_br ? {1'b0, bcond} : is_jpr ? 2'd3 : 2'd0;
               nxt       = (is_br || is_wwd || is_jpr) ? S_IF : (is_lwd || is_swd) ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            i_or_d    = 1'b1;
            mem_read  = is_lwd;
            mem_write = is_swd;
            pc_write  = is_swd && ack;
            nxt       = to ? S_HALT : !ack ? S_MEM : is_lwd ? S_WB : S_IF;
         end
         S_WB: begin
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            mem_to_reg = is_lwd;
            pc_source  = is_jal ? 2'd2 : is_jrl ? 2'd3 : 2'd0;
            nxt        = S_IF;
         end
         S_HALT: halt = 1'b1;
         default: nxt = S_IF;
      endcase
      if (reset) begin
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         i_or_d     = 1'b0;
         ir_write   = 1'b0;
         ab_write   = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'd0;
         pc_write   = 1'b0;
         pc_source  = 2'd0;
         reg_write  = 1'b0;
         mem_to_reg = 1'b0;
         wwd        = 1'b0;
         halt       = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st         <= S_IF;
         ex_cnt     <= 4'd0;
         wait_cnt   <= '0;
         op_q       <= 4'd0;
         fn_q       <= 6'd0;
         inst_count <= '0;
         mem_err    <= 1'b0;
      end else begin
         st <= nxt;
         if (st == S_ID) begin
            op_q <= opcode;
            fn_q <= func_code;
         end
         ex_cnt   <= (st == S_EX && nxt == S_EX) ? ex_cnt + 4'd1 : 4'd0;
         wait_cnt <= (MEM_TIMEOUT > 0 && mem_st && nxt == st && !mem_ack) ? wait_cnt + WW'(1) : '0;
         if (pc_write) inst_count <= inst_count + CNT_W'(1);
         if (to) mem_err <= 1'b1;
      end
   end
endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Parametrised multicycle control FSM for the 16-bit TSC CPU. It replaces the fixed-count IF1..IF3 / EX1..EX4 / MEM1..MEM3 sequencing with handshake-driven memory stages, a configurable EX length and an optional memory timeout. The branch/PC-select decision is folded into the block, and the block keeps a retired-instruction counter. It sits between the instruction register (opcode/func_code) and the multicycle datapath, memory port and register file.

## Interface
Parameters:
- EX_CYCLES, default 1: EX stage length in cycles. Legal range 1..15.
- MEM_TIMEOUT, default 0: maximum number of wait cycles for mem_ack. 0 disables the timeout.
- CNT_W, default 16: width of inst_count.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  4  IR[15:12]; valid from ID onward.
- func_code  in  6  IR[5:0].
- bcond  in  1  branch condition from the ALU; sampled in the last EX cycle.
- mem_ack  in  1  memory completion for the current request.
- state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
- mem_read, mem_write  out  1 each  memory strobes.
- i_or_d  out  1  memory address source: 0=PC, 1=ALUOut.
- ir_write  out  1  IR load enable.
- ab_write  out  1  A/B latch load enable.
- alu_src_a  out  1  0=PC, 1=A.
- alu_src_b  out  2  0=B, 1=constant 1, 2=sign/zero-extended immediate.
- pc_write  out  1  PC load enable; also marks instruction retire.
- pc_source  out  2  0=PC+1, 1=branch target, 2=jump target, 3=A (register).
- reg_write, mem_to_reg  out  1 each  register-file write controls.
- wwd  out  1  output-port strobe.
- halt  out  1  asserted in HALT.
- mem_err  out  1  sticky timeout flag.
- inst_count  out  CNT_W  retired-instruction count.

## Operation
Opcode encodings come from the shared opcode header:
- Branches BNE..BLZ = 0..3.
- Immediates ADI/ORI/LHI = 4..6; LWD = 7, SWD = 8.
- JMP = 9, JAL = 10.
- R-type = 15, with func JPR = 25, JRL = 26, WWD = 28, HLT = 29.
- Opcodes 11..14 and undefined R-type func codes are illegal.

Per-state outputs and transitions:
- IF: mem_read=1, i_or_d=0. Held until mem_ack. In the ack cycle ir_write=1; next state ID.
- ID: ab_write=1 for one cycle.
  - HLT goes to HALT.
  - JMP asserts pc_write with pc_source=2, then goes to IF.
  - Illegal instructions retire as NOP: pc_write with pc_source=0, then IF.
  - All other instructions go to EX.
- EX: lasts EX_CYCLES cycles, counted by ex_cnt.
  - alu_src_a=1, except JAL which uses 0.
  - alu_src_b=0 for R-type and branches, 2 for ADI/ORI/LHI/LWD/SWD, 1 for JAL.
  - In the last EX cycle:
    - Branches assert pc_write with pc_source = bcond ? 1 : 0, then go to IF.
    - WWD asserts wwd plus pc_write with pc_source=0, then goes to IF.
    - JPR asserts pc_write with pc_source=3, then goes to IF.
    - LWD/SWD go to MEM.
    - Everything else goes to WB.
- MEM: i_or_d=1. mem_read=1 for LWD, mem_write=1 for SWD. Held until mem_ack.
  - SWD: the ack cycle asserts pc_write with pc_source=0, then goes to IF.
  - LWD: goes to WB.
- WB: reg_write=1 and pc_write=1. mem_to_reg=1 only for LWD. pc_source=2 for JAL, 3 for JRL, 0 otherwise. Next state IF.
- HALT: halt=1, all strobes 0. The block stays in HALT until reset.

Outside EX, alu_src_a=0 and alu_src_b=0.

Counters:
- inst_count increments by 1 in every cycle with pc_write=1 and wraps modulo 2^CNT_W. HLT does not count.
- Timeout: when MEM_TIMEOUT>0, wait_cnt increments each IF/MEM cycle with mem_ack=0 and clears on ack or state change. When wait_cnt reaches MEM_TIMEOUT, the next state is HALT and mem_err is set to 1. mem_err clears only on reset.

## Timing
- Reset is asynchronous. While reset=1: state=IF; ex_cnt, wait_cnt, inst_count and mem_err are 0; every output is forced to 0, including mem_read.
- On the first edge after deassertion the FSM is in IF with mem_read=1.
- Output timing:
  - Outputs are decoded from state and registered opcode. ir_write and the MEM-stage pc_write are additionally combinational in mem_ack, i.e. Mealy.
  - A mem_ack arriving in the same cycle the request is raised completes that cycle.
  - A mem_ack outside IF/MEM is ignored.
- Latency, with mem_ack in the first request cycle (IF_n = number of IF cycles until ack, MEM_n likewise):
  - R-type: 3 + EX_CYCLES cycles.
  - LWD: 4 + EX_CYCLES cycles.
  - SWD and branches: 3 + EX_CYCLES and 2 + EX_CYCLES cycles respectively.
  - In general each instruction takes IF_n + MEM_n + fixed stages.
- Timeout takes priority over a simultaneous mem_ack: if wait_cnt == MEM_TIMEOUT, the block goes to HALT.
- Reset asserted mid-instruction aborts it with no retire count.
- inst_count wrap: 2^CNT_W − 1 rolls to 0.

## Test plan
- ADD (op 15, func 0), EX_CYCLES=2, mem_ack on the 3rd IF cycle. Required: states IF×3, ID, EX×2, WB; ir_write only in the 3rd IF cycle; WB cycle has reg_write=1, pc_write=1, pc_source=0; inst_count 0→1.
- BEQ (op 1):
  - with bcond=1: last EX cycle has pc_write=1, pc_source=1, then IF;
  - with bcond=0: pc_source=0;
  - reg_write is never asserted in either case.
- LWD (op 7), mem_ack delayed 4 cycles in MEM. Required: mem_read=1 and i_or_d=1 for 5 MEM cycles, then WB with reg_write=1 and mem_to_reg=1.
- JAL (op 10). Required: EX with alu_src_a=0 and alu_src_b=1, then WB with reg_write=1, pc_write=1, pc_source=2. HLT (15/29) goes ID→HALT, halt stays 1 for 20 cycles, and inst_count is unchanged.
- MEM_TIMEOUT=8 with mem_ack held 0 in IF. Required: HALT after 8 wait cycles, mem_err=1, halt=1, and the state persists.
- Reset asserted mid-MEM of SWD. Required: immediately state=0 with all outputs 0; after release, IF with mem_read=1 and inst_count=0. Also verify inst_count wrap with CNT_W=2: the 4th retire gives 0.
